// File: rtl/wam_scr.sv
// wam_scr: whack-a-mole score counter.
// Detects rising edges on each hit line and adds the number of new hits
// to a 3-digit BCD score that wraps modulo 1000. cout0 flags a carry out
// of the ones digit on the update that produced it.
module wam_scr #(
  parameter int DIGITS = 3,
  parameter int HITS   = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [HITS-1:0]       hit,
  output logic [4*DIGITS-1:0]   num,
  output logic                  cout0
);

  logic [HITS-1:0] hit_q;
  logic [HITS-1:0] rise;
  logic [3:0]      n;

  logic [3:0] d0_q, d0_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d2_q, d2_d;
  logic       cout0_q, cout0_d;

  logic [4:0] s0;
  logic [4:0] s0_wrap;
  logic       c0;
  logic       c1;

  // Per-line rising-edge detect against the previous sample.
  for (genvar gi = 0; gi < HITS; gi++) begin : g_rise
    assign rise[gi] = hit[gi] & ~hit_q[gi];
  end

  // Count how many lines rose this cycle (0..8 fits in 4 bits).
  always_comb begin
    n = 4'd0;
    for (int i = 0; i < HITS; i++) begin
      n = n + {3'd0, rise[i]};
    end
  end

  // BCD add of n into the ones digit, rippling a single carry upward.
  always_comb begin
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    c0      = 1'b0;
    c1      = 1'b0;
    s0      = {1'b0, d0_q} + {1'b0, n};
    s0_wrap = s0 - 5'd10;

    if (s0 > 5'd9) begin
      d0_d = s0_wrap[3:0];
      c0   = 1'b1;
    end else begin
      d0_d = s0[3:0];
    end

    if (c0) begin
      if (d1_q == 4'd9) begin
        d1_d = 4'd0;
        c1   = 1'b1;
      end else begin
        d1_d = d1_q + 4'd1;
      end
    end

    // Hundreds wraps to zero with no overflow indication.
    if (c1) begin
      if (d2_q == 4'd9) begin
        d2_d = 4'd0;
      end else begin
        d2_d = d2_q + 4'd1;
      end
    end

    cout0_d = c0;
  end

  // State registers; clear wins over any edge seen in the same cycle, and the
  // hit sample is still captured so lines high at release never score.
  always_ff @(posedge clk) begin
    hit_q <= hit;
    if (clr) begin
      d0_q    <= 4'd0;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      cout0_q <= 1'b0;
    end else begin
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      cout0_q <= cout0_d;
    end
  end

  assign num   = {d2_q, d1_q, d0_q};
  assign cout0 = cout0_q;

endmodule

// File: tb/tb_wam_scr.sv
// Directed testbench for wam_scr.
module tb_wam_scr;

  logic        clk;
  logic        clr;
  logic [7:0]  hit;
  logic [11:0] num;
  logic        cout0;

  int errors = 0;
  int checks = 0;

  wam_scr #(.DIGITS(3), .HITS(8)) dut (
    .clk   (clk),
    .clr   (clr),
    .hit   (hit),
    .num   (num),
    .cout0 (cout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] h);
    clr = 1'b1;
    hit = h;
    tick();
    clr = 1'b0;
  endtask

  // Adds 8 per call: all lines rise, then all fall.
  task automatic pulse_all(input int count);
    for (int i = 0; i < count; i++) begin
      hit = 8'hFF;
      tick();
      hit = 8'h00;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset(8'h00);
    checks++;
    if (num !== 12'h000 || cout0 !== 1'b0) begin
      errors++;
      $display("FAIL reset: num=%h cout0=%b expected num=000 cout0=0", num, cout0);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (num !== 12'h000) begin
      errors++;
      $display("FAIL reset_idle: num=%h expected 000", num);
    end
    $display("test_reset: num=%h cout0=%b", num, cout0);
  endtask

  task automatic test_toggle();
    do_reset(8'h00);
    for (int k = 1; k <= 10; k++) begin
      hit = 8'h01;
      tick();
      checks++;
      if (num !== to_bcd(k) || cout0 !== (k == 10)) begin
        errors++;
        $display("FAIL toggle_rise%0d: num=%h cout0=%b expected num=%h cout0=%b",
                 k, num, cout0, to_bcd(k), (k == 10));
      end
      hit = 8'h00;
      tick();
      checks++;
      if (num !== to_bcd(k) || cout0 !== 1'b0) begin
        errors++;
        $display("FAIL toggle_fall%0d: num=%h cout0=%b expected num=%h cout0=0",
                 k, num, cout0, to_bcd(k));
      end
    end
    $display("test_toggle: num=%h", num);
  endtask

  task automatic test_held();
    do_reset(8'h00);
    hit = 8'h08;
    tick();
    checks++;
    if (num !== 12'h001) begin
      errors++;
      $display("FAIL held_first: num=%h expected 001", num);
    end
    for (int i = 0; i < 19; i++) tick();
    checks++;
    if (num !== 12'h001 || cout0 !== 1'b0) begin
      errors++;
      $display("FAIL held_20: num=%h cout0=%b expected num=001 cout0=0", num, cout0);
    end
    do_reset(8'h08);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (num !== 12'h000) begin
      errors++;
      $display("FAIL held_at_reset: num=%h expected 000", num);
    end
    hit = 8'h00;
    $display("test_held: num=%h", num);
  endtask

  task automatic test_simultaneous();
    do_reset(8'h00);
    for (int i = 0; i < 5; i++) begin
      hit = 8'h01;
      tick();
      hit = 8'h00;
      tick();
    end
    checks++;
    if (num !== 12'h005) begin
      errors++;
      $display("FAIL simul_pre: num=%h expected 005", num);
    end
    hit = 8'hFF;
    tick();
    checks++;
    if (num !== 12'h013 || cout0 !== 1'b1) begin
      errors++;
      $display("FAIL simul_all: num=%h cout0=%b expected num=013 cout0=1", num, cout0);
    end
    tick();
    checks++;
    if (num !== 12'h013 || cout0 !== 1'b0) begin
      errors++;
      $display("FAIL simul_hold: num=%h cout0=%b expected num=013 cout0=0", num, cout0);
    end
    hit = 8'h00;
    tick();
    $display("test_simultaneous: num=%h", num);
  endtask

  task automatic test_wrap();
    do_reset(8'h00);
    pulse_all(124);          // 992
    hit = 8'h3F;             // +6 -> 998
    tick();
    hit = 8'h00;
    tick();
    checks++;
    if (num !== 12'h998) begin
      errors++;
      $display("FAIL wrap_pre: num=%h expected 998", num);
    end
    hit = 8'h07;             // +3 -> 1001 wraps to 001
    tick();
    checks++;
    if (num !== 12'h001 || cout0 !== 1'b1) begin
      errors++;
      $display("FAIL wrap: num=%h cout0=%b expected num=001 cout0=1", num, cout0);
    end
    tick();
    checks++;
    if (num !== 12'h001 || cout0 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_after: num=%h cout0=%b expected num=001 cout0=0", num, cout0);
    end
    hit = 8'h00;
    tick();
    $display("test_wrap: num=%h", num);
  endtask

  task automatic test_clr_mid();
    do_reset(8'h00);
    pulse_all(57);           // 456
    hit = 8'h01;
    tick();
    hit = 8'h00;
    tick();
    checks++;
    if (num !== 12'h457) begin
      errors++;
      $display("FAIL clr_mid_pre: num=%h expected 457", num);
    end
    clr = 1'b1;
    hit = 8'h01;
    tick();
    checks++;
    if (num !== 12'h000 || cout0 !== 1'b0) begin
      errors++;
      $display("FAIL clr_mid: num=%h cout0=%b expected num=000 cout0=0", num, cout0);
    end
    clr = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (num !== 12'h000) begin
      errors++;
      $display("FAIL clr_mid_after: num=%h expected 000", num);
    end
    hit = 8'h00;
    $display("test_clr_mid: num=%h", num);
  endtask

  initial begin
    clr = 1'b1;
    hit = 8'h00;
    tick();
    test_reset();
    test_toggle();
    test_held();
    test_simultaneous();
    test_wrap();
    test_clr_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
